// File: rtl/add_seq_pkg.sv
// Shared types and elaboration helpers for the slice-sequenced adder controller.
package add_seq_pkg;

  // Controller phases: waiting for a grant, stepping slices, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slice steps needed for one full-width addition.
  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // True when the operand width splits into whole slices.
  function automatic bit slice_fits(input int width, input int slice);
    return (slice > 0) && ((width % slice) == 0);
  endfunction

  // Requester index width; a single requester still gets a 1-bit id.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Request, response and adder-slice signals of add_seq_ctrl.
//
// Handshakes: a request transfers on a rising edge where i_req_valid[r] and
// o_req_ready[r] are both high; a response transfers on a rising edge where
// o_rsp_valid and i_rsp_ready are both high. A requester holds valid and its
// operands stable until its ready pulse; the controller holds o_rsp_* stable
// until the response transfers. Ready never depends on anything but state and
// the valids, so there is no combinational loop through the handshake.
interface add_seq_ctrl_if #(
  parameter int WIDTH   = 32,
  parameter int SLICE   = 8,
  parameter int NUM_REQ = 2
);
  import add_seq_pkg::*;

  localparam int IDW = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]       i_req_valid;
  logic [NUM_REQ-1:0]       o_req_ready;
  logic [NUM_REQ*WIDTH-1:0] i_req_a;
  logic [NUM_REQ*WIDTH-1:0] i_req_b;
  logic [NUM_REQ-1:0]       i_req_cin;

  logic                     o_rsp_valid;
  logic                     i_rsp_ready;
  logic [IDW-1:0]           o_rsp_id;
  logic [WIDTH-1:0]         o_rsp_sum;
  logic                     o_rsp_cout;

  logic [SLICE-1:0]         o_slice_a;
  logic [SLICE-1:0]         o_slice_b;
  logic                     o_slice_cin;
  logic [SLICE-1:0]         i_slice_sum;
  logic                     i_slice_cout;

  // Controller side.
  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_cin, i_rsp_ready,
           i_slice_sum, i_slice_cout,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_sum, o_rsp_cout,
           o_slice_a, o_slice_b, o_slice_cin
  );

  // Requester / adder-slice side.
  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_cin, i_rsp_ready,
           i_slice_sum, i_slice_cout,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_sum, o_rsp_cout,
           o_slice_a, o_slice_b, o_slice_cin
  );

endinterface

// File: rtl/add_seq_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               grant_any
);

  // Scan requesters starting at ptr, wrapping, and keep only the first hit.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!grant_any && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = IDW'(j);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Shares one external SLICE-bit adder among NUM_REQ requesters. Each
// WIDTH-bit add is stepped LSB slice first with the carry kept in a register;
// grants are round-robin and results return tagged with the requester id.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE   = 8,
  parameter int NUM_REQ = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  add_seq_ctrl_if.slave bus,
  output state_t       o_dbg_state
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDW    = id_width(NUM_REQ);
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0]  K_LAST  = KW'(NSLICE - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NUM_REQ - 1);

  generate
    if (!slice_fits(WIDTH, SLICE)) begin : g_bad_cfg
      $error("add_seq_ctrl: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic [KW-1:0]    k;
  logic [IDW-1:0]   id_reg;
  logic [IDW-1:0]   rr_ptr;
  int               k_base;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req       (bus.i_req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign k_base      = int'(k) * SLICE;
  assign o_dbg_state = state;

  // Response fields come straight from the held registers so they stay
  // stable for as long as DONE is back-pressured.
  assign bus.o_rsp_valid = (state == DONE);
  assign bus.o_rsp_sum   = sum_reg;
  assign bus.o_rsp_cout  = carry;
  assign bus.o_rsp_id    = id_reg;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: grant in IDLE, step through slices, wait for the response.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_any)          state_nx = RUN;
      RUN:     if (k == K_LAST)        state_nx = DONE;
      DONE:    if (bus.i_rsp_ready)    state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  // Ready only in IDLE; slice operands only in RUN, zero otherwise.
  always_comb begin
    bus.o_req_ready = '0;
    bus.o_slice_a   = '0;
    bus.o_slice_b   = '0;
    bus.o_slice_cin = 1'b0;
    if (state == IDLE) begin
      bus.o_req_ready = grant;
    end
    if (state == RUN) begin
      bus.o_slice_a   = a_reg[k_base +: SLICE];
      bus.o_slice_b   = b_reg[k_base +: SLICE];
      bus.o_slice_cin = carry;
    end
  end

  // Datapath: capture operands on grant, accumulate slice sums, advance
  // the round-robin pointer past the requester just served.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      k       <= '0;
      id_reg  <= '0;
      rr_ptr  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            a_reg  <= bus.i_req_a[int'(grant_idx)*WIDTH +: WIDTH];
            b_reg  <= bus.i_req_b[int'(grant_idx)*WIDTH +: WIDTH];
            carry  <= bus.i_req_cin[grant_idx];
            id_reg <= grant_idx;
            k      <= '0;
          end
        end
        RUN: begin
          sum_reg[k_base +: SLICE] <= bus.i_slice_sum;
          carry                    <= bus.i_slice_cout;
          k                        <= k + 1'b1;
        end
        DONE: begin
          if (bus.i_rsp_ready) begin
            rr_ptr <= (id_reg == ID_LAST) ? '0 : id_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl with a behavioural 8-bit adder on the slice ports.
module tb_add_seq_ctrl;
  import add_seq_pkg::*;

  localparam int W  = 32;
  localparam int N_RAND = 1000;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     n_checks;
  int     n_pass;

  add_seq_ctrl_if #(.WIDTH(W), .SLICE(8), .NUM_REQ(2)) bus ();

  add_seq_ctrl #(.WIDTH(W), .SLICE(8), .NUM_REQ(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Behavioural adder slice.
  assign {bus.i_slice_cout, bus.i_slice_sum} =
    {1'b0, bus.o_slice_a} + {1'b0, bus.o_slice_b} + {8'd0, bus.o_slice_cin};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requesters must hold valid and operands until their ready pulse.
  logic [1:0]   pv, pr, pc;
  logic [63:0]  pa, pb;
  always @(posedge clk) begin
    if (rst_n) begin
      for (int r = 0; r < 2; r++) begin
        if (pv[r] && !pr[r]) begin
          n_checks++;
          if (!bus.i_req_valid[r] || bus.i_req_a[r*32 +: 32] !== pa[r*32 +: 32] ||
              bus.i_req_b[r*32 +: 32] !== pb[r*32 +: 32] || bus.i_req_cin[r] !== pc[r])
            $display("FAIL req_hold r%0d: valid=%b a=%h b=%h", r, bus.i_req_valid[r],
                     bus.i_req_a[r*32 +: 32], bus.i_req_b[r*32 +: 32]);
          else n_pass++;
        end
      end
    end
    pv <= rst_n ? bus.i_req_valid : 2'b00;
    pr <= bus.o_req_ready;
    pa <= bus.i_req_a;
    pb <= bus.i_req_b;
    pc <= bus.i_req_cin;
  end

  // Driver tasks
  task automatic drive_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic cin);
    bus.i_req_a[r*32 +: 32] = a;
    bus.i_req_b[r*32 +: 32] = b;
    bus.i_req_cin[r]        = cin;
    bus.i_req_valid[r]      = 1'b1;
  endtask

  // Returns in the cycle where o_req_ready[r] is high (accept on the next edge).
  task automatic wait_grant(input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.o_req_ready[r]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called on the negedge after the accept edge; lat counts edges past accept.
  task automatic wait_rsp(output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.o_rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp();
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_req_valid = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_req_cin   = '0;
    bus.i_rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.o_req_ready !== 2'b00) $display("FAIL rst_req_ready: got %b want 00", bus.o_req_ready); else n_pass++;
    n_checks++; if (bus.o_rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", bus.o_rsp_valid); else n_pass++;
    n_checks++; if (bus.o_rsp_id !== 1'b0) $display("FAIL rst_rsp_id: got %b want 0", bus.o_rsp_id); else n_pass++;
    n_checks++; if (bus.o_rsp_sum !== 32'h0) $display("FAIL rst_rsp_sum: got %h want 0", bus.o_rsp_sum); else n_pass++;
    n_checks++; if (bus.o_rsp_cout !== 1'b0) $display("FAIL rst_rsp_cout: got %b want 0", bus.o_rsp_cout); else n_pass++;
    n_checks++; if (bus.o_slice_a !== 8'h0 || bus.o_slice_b !== 8'h0 || bus.o_slice_cin !== 1'b0)
      $display("FAIL rst_slice: got a=%h b=%h cin=%b want 0", bus.o_slice_a, bus.o_slice_b, bus.o_slice_cin); else n_pass++;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_carry_ripple();
    bit ok; int lat;
    drive_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_grant(0, ok);
    n_checks++; if (!ok || bus.o_req_ready !== 2'b01) $display("FAIL ripple_grant: got %b want 01", bus.o_req_ready); else n_pass++;
    @(negedge clk);
    bus.i_req_valid[0] = 1'b0;
    #1;
    n_checks++; if (bus.o_slice_a !== 8'hFF || bus.o_slice_b !== 8'h01 || bus.o_slice_cin !== 1'b0)
      $display("FAIL ripple_slice0: got a=%h b=%h cin=%b want ff 01 0", bus.o_slice_a, bus.o_slice_b, bus.o_slice_cin); else n_pass++;
    wait_rsp(ok, lat);
    n_checks++; if (!ok || lat != 4) $display("FAIL ripple_latency: got %0d want 4", lat); else n_pass++;
    n_checks++; if (bus.o_rsp_sum !== 32'h0 || bus.o_rsp_cout !== 1'b1 || bus.o_rsp_id !== 1'b0)
      $display("FAIL ripple_rsp: got sum=%h cout=%b id=%b want 0 1 0", bus.o_rsp_sum, bus.o_rsp_cout, bus.o_rsp_id); else n_pass++;
    finish_rsp();
    #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b0) $display("FAIL ripple_valid_drop: got %b want 0", bus.o_rsp_valid); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_carry_in();
    bit ok; int lat;
    drive_req(1, 32'h1234_5678, 32'h0, 1'b1);
    wait_grant(1, ok);
    n_checks++; if (!ok || bus.o_req_ready !== 2'b10) $display("FAIL cin_grant: got %b want 10", bus.o_req_ready); else n_pass++;
    @(negedge clk);
    bus.i_req_valid[1] = 1'b0;
    wait_rsp(ok, lat);
    n_checks++; if (!ok || bus.o_rsp_sum !== 32'h1234_5679 || bus.o_rsp_cout !== 1'b0 || bus.o_rsp_id !== 1'b1)
      $display("FAIL cin_rsp: got sum=%h cout=%b id=%b want 12345679 0 1", bus.o_rsp_sum, bus.o_rsp_cout, bus.o_rsp_id); else n_pass++;
    finish_rsp();
  endtask

  task automatic test_arbitration();
    bit ok; int lat; int r;
    logic [1:0]  exp_g [4];
    logic [32:0] exp_s [2];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_s = '{33'h0_3333_3333, 33'h1_0000_0001};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int round = 0; round < 4; round++) begin
      if (round % 2 == 0) begin
        drive_req(0, 32'h1111_1111, 32'h2222_2222, 1'b0);
        drive_req(1, 32'hA000_0000, 32'h6000_0000, 1'b1);
      end
      #1;
      n_checks++; if (bus.o_req_ready !== exp_g[round]) $display("FAIL arb_grant%0d: got %b want %b", round, bus.o_req_ready, exp_g[round]); else n_pass++;
      r = (exp_g[round] == 2'b01) ? 0 : 1;
      @(negedge clk);
      bus.i_req_valid[r] = 1'b0;
      #1;
      n_checks++; if (bus.o_req_ready !== 2'b00) $display("FAIL arb_busy%0d: got %b want 00", round, bus.o_req_ready); else n_pass++;
      wait_rsp(ok, lat);
      n_checks++; if (!ok || bus.o_rsp_id !== r[0] || {bus.o_rsp_cout, bus.o_rsp_sum} !== exp_s[r])
        $display("FAIL arb_rsp%0d: got id=%b sum=%h cout=%b want id=%0d %h", round, bus.o_rsp_id, bus.o_rsp_sum, bus.o_rsp_cout, r, exp_s[r]); else n_pass++;
      finish_rsp();
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat;
    drive_req(0, 32'h8000_0001, 32'h8000_0002, 1'b1);
    wait_grant(0, ok);
    n_checks++; if (!ok) $display("FAIL bp_grant: got 0 want 1"); else n_pass++;
    @(negedge clk);
    bus.i_req_valid[0] = 1'b0;
    drive_req(1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    wait_rsp(ok, lat);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (!bus.o_rsp_valid || bus.o_rsp_sum !== 32'h0000_0004 || bus.o_rsp_cout !== 1'b1 || bus.o_rsp_id !== 1'b0)
        $display("FAIL bp_hold%0d: got v=%b sum=%h cout=%b id=%b want 1 00000004 1 0", i, bus.o_rsp_valid, bus.o_rsp_sum, bus.o_rsp_cout, bus.o_rsp_id); else n_pass++;
      n_checks++; if (bus.o_req_ready !== 2'b00) $display("FAIL bp_no_grant%0d: got %b want 00", i, bus.o_req_ready); else n_pass++;
      @(negedge clk);
    end
    finish_rsp();
    wait_grant(1, ok);
    n_checks++; if (!ok || bus.o_req_ready !== 2'b10) $display("FAIL bp_next_grant: got %b want 10", bus.o_req_ready); else n_pass++;
    @(negedge clk);
    bus.i_req_valid[1] = 1'b0;
    wait_rsp(ok, lat);
    n_checks++; if (!ok || bus.o_rsp_sum !== 32'h1010_1010 || bus.o_rsp_id !== 1'b1)
      $display("FAIL bp_next_rsp: got sum=%h id=%b want 10101010 1", bus.o_rsp_sum, bus.o_rsp_id); else n_pass++;
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; bit seen;
    drive_req(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    wait_grant(0, ok);
    @(negedge clk);
    bus.i_req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (dbg_state !== RUN) $display("FAIL rmid_in_run: got %0d want %0d", dbg_state, RUN); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_rsp_valid !== 1'b0 || bus.o_rsp_sum !== 32'h0 || bus.o_rsp_cout !== 1'b0 || bus.o_rsp_id !== 1'b0)
      $display("FAIL rmid_rsp_clear: got v=%b sum=%h cout=%b id=%b want 0", bus.o_rsp_valid, bus.o_rsp_sum, bus.o_rsp_cout, bus.o_rsp_id); else n_pass++;
    n_checks++; if (bus.o_slice_a !== 8'h0 || bus.o_slice_b !== 8'h0 || bus.o_slice_cin !== 1'b0 || bus.o_req_ready !== 2'b00 || dbg_state !== IDLE)
      $display("FAIL rmid_slice_clear: got a=%h b=%h cin=%b rdy=%b st=%0d want 0", bus.o_slice_a, bus.o_slice_b, bus.o_slice_cin, bus.o_req_ready, dbg_state); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.o_rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen) $display("FAIL rmid_no_rsp: got 1 want 0"); else n_pass++;
    drive_req(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    wait_grant(0, ok);
    @(negedge clk);
    bus.i_req_valid[0] = 1'b0;
    wait_rsp(ok, lat);
    n_checks++; if (!ok || lat != 4 || bus.o_rsp_sum !== 32'h0001_0000 || bus.o_rsp_cout !== 1'b0)
      $display("FAIL rmid_reissue: got lat=%0d sum=%h cout=%b want 4 00010000 0", lat, bus.o_rsp_sum, bus.o_rsp_cout); else n_pass++;
    finish_rsp();
  endtask

  // Scoreboard: expected {id, cout, sum} pushed at grant, popped at response.
  task automatic test_random();
    logic [33:0] exp_q[$];
    logic [33:0] exp_v;
    logic [33:0] got_v;
    logic [31:0] a, b;
    logic        c;
    logic [32:0] full;
    logic [1:0]  gnt;
    bit          pend [2];
    int          waited [2];
    int          issued, done;
    pend = '{1'b0, 1'b0};
    waited = '{0, 0};
    issued = 0;
    done = 0;
    for (int cyc = 0; cyc < 30000 && done < N_RAND; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          bus.i_req_valid[r] = 1'b0;
          if (issued < N_RAND && $urandom_range(0, 2) == 0) begin
            a = $urandom;
            b = $urandom;
            c = 1'($urandom_range(0, 1));
            drive_req(r, a, b, c);
            pend[r] = 1'b1;
            waited[r] = 0;
            issued++;
          end
        end
      end
      bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      gnt = bus.o_req_ready;
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        got_v = {bus.o_rsp_id, bus.o_rsp_cout, bus.o_rsp_sum};
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_rsp: got %h want no response", got_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (got_v !== exp_v) $display("FAIL rand_rsp%0d: got %h want %h", done, got_v, exp_v);
          else n_pass++;
        end
        done++;
      end
      for (int r = 0; r < 2; r++) begin
        if (gnt[r]) begin
          full = {1'b0, bus.i_req_a[r*32 +: 32]} + {1'b0, bus.i_req_b[r*32 +: 32]} + {32'd0, bus.i_req_cin[r]};
          exp_q.push_back({r[0], full});
          n_checks++;
          if (waited[r] > 1) $display("FAIL rand_starve r%0d: got %0d want <=1", r, waited[r]);
          else n_pass++;
          pend[r] = 1'b0;
          if (pend[1-r]) waited[1-r]++;
        end
      end
      @(negedge clk);
    end
    n_checks++; if (done != N_RAND) $display("FAIL rand_count: got %0d want %0d", done, N_RAND); else n_pass++;
    bus.i_rsp_ready = 1'b0;
    bus.i_req_valid = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_carry_ripple();
    test_carry_in();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
